// File: rtl/uart_cmd_parser.sv
// Framed read/write command decoder fed by UART byte strobes, with a valid/ready host port.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 52070
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_wr,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ErrOverrun = 2'd0;
  localparam logic [1:0] ErrOpcode  = 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [1:0] ErrCsum    = 2'd2;
`endif
  localparam logic [1:0] ErrTimeout = 2'd3;

  localparam logic [7:0] OpWrite = 8'h01;
  localparam logic [7:0] OpRead  = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StOp,
    StAddr,
    StData,
`ifdef UART_CMD_CHECKSUM_EN
    StCsum,
`endif
    StIssue
  } state_e;

  // State entered after the last address/data byte of a frame.
`ifdef UART_CMD_CHECKSUM_EN
  localparam state_e StTail = StCsum;
`else
  localparam state_e StTail = StIssue;
`endif

  state_e          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            cmd_wr_q, cmd_wr_d;
  logic [23:0]     cmd_addr_q, cmd_addr_d;
  logic [15:0]     cmd_wdata_q, cmd_wdata_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            in_frame;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (in_valid) begin
      if (state_q == StIdle) begin
        csum_d = '0;
      end else if (state_q == StOp || state_q == StAddr || state_q == StData) begin
        csum_d = csum_q ^ in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign in_frame = (state_q != StIdle) && (state_q != StIssue);

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    tmo_d       = '0;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    // A byte on the expiry cycle keeps the frame alive.
    if (in_frame && !in_valid) begin
      if (tmo_q == TmoLast) begin
        state_d    = StIdle;
        err_d      = 1'b1;
        err_code_d = ErrTimeout;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (in_valid && in_data == HEADER) begin
          state_d = StOp;
        end
      end
      StOp: begin
        if (in_valid) begin
          if (in_data == OpWrite || in_data == OpRead) begin
            cmd_wr_d    = (in_data == OpWrite);
            cmd_wdata_d = '0;
            bcnt_d      = '0;
            state_d     = StAddr;
          end else begin
            state_d    = StIdle;
            err_d      = 1'b1;
            err_code_d = ErrOpcode;
          end
        end
      end
      StAddr: begin
        if (in_valid) begin
          cmd_addr_d = {cmd_addr_q[15:0], in_data};
          bcnt_d     = bcnt_q + 2'd1;
          if (bcnt_q == 2'd2) begin
            bcnt_d  = '0;
            state_d = cmd_wr_q ? StData : StTail;
          end
        end
      end
      StData: begin
        if (in_valid) begin
          cmd_wdata_d = {cmd_wdata_q[7:0], in_data};
          bcnt_d      = bcnt_q + 2'd1;
          if (bcnt_q == 2'd1) begin
            bcnt_d  = '0;
            state_d = StTail;
          end
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      StCsum: begin
        if (in_valid) begin
          if (in_data == csum_q) begin
            state_d = StIssue;
          end else begin
            state_d    = StIdle;
            err_d      = 1'b1;
            err_code_d = ErrCsum;
          end
        end
      end
`endif
      StIssue: begin
        // No buffering: bytes arriving while a command is pending are lost.
        if (in_valid) begin
          err_d      = 1'b1;
          err_code_d = ErrOverrun;
        end
        if (cmd_valid_q && cmd_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_valid_d = (state_d == StIssue);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bcnt_q      <= '0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frames are described at command level, expected commands and
// error codes are queued, and a free-running monitor checks whatever the DUT presents.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int unsigned Tmo = 40;
  localparam logic [7:0]  Hdr = 8'h55;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .HEADER        (Hdr),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .err      (err),
    .err_code (err_code)
  );

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t       exp_cmd_q[$];
  logic [1:0] exp_err_q[$];
  logic [7:0] frm[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes every error strobe and every accepted command.
  initial begin : monitor
    cmd_t got;
    cmd_t held;
    cmd_t exp_c;
    logic [1:0] exp_e;
    logic holding;
    holding = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holding = 1'b0;
      end else begin
        if (err) begin
          if (exp_err_q.size() == 0) begin
            chk("err_unexpected", err, 1'b0);
          end else begin
            exp_e = exp_err_q.pop_front();
            chk("err_code", err_code, exp_e);
          end
        end
        got = {cmd_wr, cmd_addr, cmd_wdata};
        if (cmd_valid) begin
          if (holding) chk("cmd_stable", got, held);
          if (cmd_ready) begin
            holding = 1'b0;
            if (exp_cmd_q.size() == 0) begin
              chk("cmd_unexpected", cmd_valid, 1'b0);
            end else begin
              exp_c = exp_cmd_q.pop_front();
              chk("cmd_fields", got, exp_c);
            end
          end else begin
            holding = 1'b1;
            held    = got;
          end
        end else if (holding) begin
          chk("cmd_dropped_without_handshake", cmd_valid, 1'b1);
          holding = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic build_frame(input logic wr, input logic [23:0] a, input logic [15:0] d);
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] cs;
`endif
    frm = {Hdr, (wr ? 8'h01 : 8'h02), a[23:16], a[15:8], a[7:0]};
    if (wr) begin
      frm.push_back(d[15:8]);
      frm.push_back(d[7:0]);
    end
`ifdef UART_CMD_CHECKSUM_EN
    cs = 8'h00;
    for (int i = 1; i < frm.size(); i++) cs ^= frm[i];
    frm.push_back(cs);
`endif
  endtask

  // Sends frm[0..count-1]; the byte at long_gap_at lands exactly on the expiry cycle.
  task automatic send_frame(input int long_gap_at, input int count);
    for (int i = 0; i < count; i++) begin
      if (i > 0) tick((i == long_gap_at) ? int'(Tmo) - 1 : int'($urandom_range(0, 2)));
      send_byte(frm[i]);
    end
  endtask

  // mode 0: ready high beforehand; 1: ready held low; 2: held low plus a stray byte.
  task automatic good_frame(input logic wr, input logic [23:0] a, input logic [15:0] d,
                            input int mode, input int hold, input int long_gap_at);
    build_frame(wr, a, d);
    exp_cmd_q.push_back({wr, a, (wr ? d : 16'h0000)});
    cmd_ready = (mode == 0);
    send_frame(long_gap_at, frm.size());
    @(negedge clk);
    chk("cmd_valid_latency", cmd_valid, 1'b1);
    @(posedge clk);
    #1;
    if (mode != 0) begin
      tick(hold);
      if (mode == 2) begin
        exp_err_q.push_back(2'd0);
        send_byte(8'($urandom));
        tick(1);
      end
      cmd_ready = 1'b1;
      tick(1);
      @(negedge clk);
      chk("cmd_valid_clear", cmd_valid, 1'b0);
      @(posedge clk);
      #1;
      cmd_ready = 1'b0;
    end
  endtask

  task automatic garbage();
    logic [7:0] b;
    repeat ($urandom_range(1, 5)) begin
      b = 8'($urandom);
      if (b == Hdr) b = b ^ 8'h01;
      send_byte(b);
      tick($urandom_range(0, 2));
    end
  endtask

  task automatic bad_op();
    logic [7:0] op;
    do op = 8'($urandom); while (op == 8'h01 || op == 8'h02);
    exp_err_q.push_back(2'd1);
    send_byte(Hdr);
    tick($urandom_range(0, 2));
    send_byte(op);
    @(negedge clk);
    chk("bad_op_err_latency", err, 1'b1);
    @(posedge clk);
    #1;
    garbage();
  endtask

  task automatic timeout_frame(input int count);
    exp_err_q.push_back(2'd3);
    send_frame(-1, count);
    tick(Tmo);
    @(negedge clk);
    chk("timeout_err_latency", err, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_frame();
    build_frame(1'b1, 24'($urandom), 16'($urandom));
    send_frame(-1, int'($urandom_range(1, 4)));
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("reset_mid_frame_outputs", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata, err, err_code}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  task automatic bad_csum(input logic zero_cs);
    build_frame(1'($urandom), 24'($urandom), 16'($urandom));
    if (zero_cs) frm[frm.size()-1] = 8'h00;
    else frm[frm.size()-1] = ~frm[frm.size()-1];
    exp_err_q.push_back(2'd2);
    send_frame(-1, frm.size());
    @(negedge clk);
    chk("csum_err_latency", err, 1'b1);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin : driver
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b0;
    tick(3);
    @(negedge clk);
    chk("reset_outputs", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata, err, err_code}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2);

    good_frame(1'b1, 24'h123456, 16'hABCD, 0, 0, -1);
    good_frame(1'b0, 24'h000010, 16'h0000, 1, 20, -1);
    bad_op();
    good_frame(1'b1, 24'hA5A5A5, 16'h5555, 0, 0, -1);
    build_frame(1'b1, 24'h123456, 16'hABCD);
    timeout_frame(3);
    good_frame(1'b0, 24'hFEDCBA, 16'h0000, 0, 0, -1);
    good_frame(1'b1, 24'h55AA55, 16'h0F0F, 0, 0, 3);
    good_frame(1'b0, 24'h000001, 16'h0000, 2, 5, -1);
    reset_mid_frame();
    good_frame(1'b1, 24'h0000FF, 16'hFFFF, 0, 0, -1);
`ifdef UART_CMD_CHECKSUM_EN
    build_frame(1'b1, 24'h123456, 16'hABCD);
    frm[frm.size()-1] = 8'h00;
    exp_err_q.push_back(2'd2);
    send_frame(-1, frm.size());
    tick(2);
`endif

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: good_frame(1'($urandom), 24'($urandom), 16'($urandom),
                               int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), -1);
        4: bad_op();
        5: begin
          build_frame(1'($urandom), 24'($urandom), 16'($urandom));
          timeout_frame(int'($urandom_range(1, frm.size() - 1)));
        end
        6: garbage();
        7: reset_mid_frame();
`ifdef UART_CMD_CHECKSUM_EN
        8: bad_csum(1'b0);
`endif
        default: good_frame(1'($urandom), 24'($urandom), 16'($urandom),
                            0, 0, int'($urandom_range(1, 4)));
      endcase
    end

    tick(5);
    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("err_queue_drained", exp_err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
